// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, default
// reset PC / halt opcode, instruction width and a saturating counter helper.
package instruction_fetch_unit_pkg;

  localparam int unsigned INSTR_WIDTH = 32;

  localparam logic [INSTR_WIDTH-1:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [INSTR_WIDTH-1:0] HALT_INSTR_DEFAULT = 32'h0000_0073;
  localparam logic [INSTR_WIDTH-1:0] COUNT_MAX          = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } fetch_state_e;

  // Performance counters stick at all-ones instead of wrapping to zero.
  function automatic logic [INSTR_WIDTH-1:0] sat_inc(input logic [INSTR_WIDTH-1:0] value);
    return (value == COUNT_MAX) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_memory.sv
// Word-addressed program store: one write port and one registered read port.
// The array itself is never reset; only the read-data register is.
module instruction_memory
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   write_en,
  input  logic [ADDR_WIDTH-1:0]  write_addr,
  input  logic [INSTR_WIDTH-1:0] write_data,
  input  logic                   read_en,
  input  logic [ADDR_WIDTH-1:0]  read_addr,
  output logic [INSTR_WIDTH-1:0] read_data
);

  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic [INSTR_WIDTH-1:0] read_data_d;
  logic [INSTR_WIDTH-1:0] read_data_q;

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  // The read register only updates on a read, so the issued word stays put
  // for as long as the core takes to complete it.
  always_comb begin
    read_data_d = read_data_q;
    if (read_en) begin
      read_data_d = mem[read_addr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data_q <= '0;
    end else begin
      read_data_q <= read_data_d;
    end
  end

  assign read_data = read_data_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, the program memory and the fetch/stall counters,
// and hands one instruction at a time to the core with a complete handshake.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   loadEnable,
  input  logic [ADDR_WIDTH-1:0]  loadAddress,
  input  logic [INSTR_WIDTH-1:0] loadData,
  input  logic                   completeInstruction,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   validInstruction,
  output logic [31:0]            pc,
  output logic                   halted,
  output logic [31:0]            fetchCount,
  output logic [31:0]            stallCycles
);

  fetch_state_e state_q, state_d;

  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  logic [ADDR_WIDTH-1:0]  word_index;
  logic [ADDR_WIDTH-1:0]  next_word_index;
  logic [31:0]            pc_inc;
  logic                   mem_write_en;
  logic                   mem_read_en;
  logic [INSTR_WIDTH-1:0] mem_read_data;
  logic                   is_halt;

  instruction_memory #(
    .DEPTH      (IMEM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_imem (
    .clk        (clk),
    .reset      (reset),
    .write_en   (mem_write_en),
    .write_addr (loadAddress),
    .write_data (loadData),
    .read_en    (mem_read_en),
    .read_addr  (word_index),
    .read_data  (mem_read_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      fetch_count_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      fetch_count_q  <= fetch_count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Only the word-index bits advance, so the PC wraps inside the memory and
  // the byte-offset and upper bits stay zero.
  always_comb begin
    word_index      = pc_q[ADDR_WIDTH+1:2];
    next_word_index = word_index + ADDR_WIDTH'(1);
    pc_inc          = '0;
    pc_inc[ADDR_WIDTH+1:2] = next_word_index;
    is_halt         = (mem_read_data == HALT_INSTR);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (run && !loadEnable) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = run ? ISSUE : IDLE;
      end
      ISSUE: begin
        if (completeInstruction) begin
          if (is_halt) begin
            state_d = HALTED;
          end else if (run) begin
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HALTED: begin
        if (!run) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Program loads are only honoured while nothing is in flight.
  always_comb begin
    pc_d           = pc_q;
    fetch_count_d  = fetch_count_q;
    stall_cycles_d = stall_cycles_q;
    mem_write_en   = loadEnable && ((state_q == IDLE) || (state_q == HALTED));
    mem_read_en    = (state_q == FETCH);
    if (state_q == ISSUE) begin
      if (completeInstruction) begin
        pc_d          = pc_inc;
        fetch_count_d = sat_inc(fetch_count_q);
      end else begin
        stall_cycles_d = sat_inc(stall_cycles_q);
      end
    end
    if ((state_q == HALTED) && !run) begin
      pc_d = RESET_PC;
    end
  end

  always_comb begin
    instruction      = mem_read_data;
    validInstruction = (state_q == ISSUE);
    halted           = (state_q == HALTED);
    pc               = pc_q;
    fetchCount       = fetch_count_q;
    stallCycles      = stall_cycles_q;
  end

`ifndef SYNTHESIS
  pc_aligned_a : assert property (@(posedge clk) disable iff (!reset) pc_q[1:0] == 2'b00);

  held_while_stalled_a : assert property (@(posedge clk) disable iff (!reset)
    (state_q == ISSUE && !completeInstruction) |=> (state_q == ISSUE && $stable(mem_read_data)));
`endif

endmodule
